// File: rtl/perf_counter_reader.sv
// Performance-counter frame reader.
// On a start request in IDLE, all counters are captured into a snapshot in one
// edge. The snapshot is then streamed as a valid/ready frame: header, one word
// per counter, and an XOR checksum. A one-cycle done pulse follows the final
// accepted word.
module perf_counter_reader #(
  parameter int unsigned NUM_CNT = 18,
  parameter logic [15:0] MAGIC   = 16'hC0DE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [32*NUM_CNT-1:0]  cnt_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [31:0]            out_data,
  output logic [5:0]             out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam logic [31:0] HEADER        = {MAGIC, 8'h00, 8'(NUM_CNT)};
  localparam logic [5:0]  LAST_DATA_IDX = 6'(NUM_CNT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] snap_q [NUM_CNT];
  logic [31:0] csum_q;
  logic [31:0] cnt_xor;
  logic [31:0] data_word;
  logic        capture;
  logic        xfer;

  // A frame is only launched from IDLE; start is ignored everywhere else.
  assign capture = (state_q == IDLE) && start;
  assign xfer    = out_valid && out_ready;

  // XOR of the live counter bus; registered together with the snapshot so the
  // checksum always describes exactly the captured words.
  always_comb begin
    cnt_xor = 32'h0;
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      cnt_xor = cnt_xor ^ cnt_in[32*i +: 32];
    end
  end

  // Per-word snapshot registers, loaded only on the capture edge.
  generate
    for (genvar gi = 0; gi < int'(NUM_CNT); gi++) begin : g_snap
      always_ff @(posedge clk) begin
        if (reset) begin
          snap_q[gi] <= 32'h0;
        end else if (capture) begin
          snap_q[gi] <= cnt_in[32*gi +: 32];
        end
      end
    end
  endgenerate

  // Checksum register: header folded in with all captured counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= 32'h0;
    end else if (capture) begin
      csum_q <= HEADER ^ cnt_xor;
    end
  end

  // State and word-index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: advance one word per accepted transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = 6'd0;
        if (start) state_d = HDR;
      end
      HDR: begin
        if (out_ready) begin
          state_d = DATA;
          idx_d   = 6'd1;
        end
      end
      DATA: begin
        if (out_ready) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == LAST_DATA_IDX) state_d = CSUM;
        end
      end
      CSUM: begin
        if (out_ready) begin
          state_d = DONE;
          idx_d   = 6'd0;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = 6'd0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 6'd0;
      end
    endcase
  end

  // Select the snapshot word for data index idx_q (word idx_q-1).
  always_comb begin
    data_word = 32'h0;
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      if (idx_q == 6'(i + 1)) data_word = snap_q[i];
    end
  end

  // Output decode: payload fields are forced to zero whenever no word is offered.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 32'h0;
    out_idx   = 6'd0;
    out_last  = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    case (state_q)
      HDR: begin
        out_valid = 1'b1;
        out_data  = HEADER;
        out_idx   = idx_q;
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = data_word;
        out_idx   = idx_q;
      end
      CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        out_idx   = idx_q;
        out_last  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // xfer is kept as a named handshake term for readability in waveforms.
  logic unused_xfer;
  assign unused_xfer = xfer;

endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed testbench for perf_counter_reader (NUM_CNT = 18).
module tb_perf_counter_reader;

  localparam int N  = 18;
  localparam int FW = N + 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [32*N-1:0] cnt_in;
  logic            out_ready;
  logic            out_valid;
  logic [31:0]     out_data;
  logic [5:0]      out_idx;
  logic            out_last;
  logic            busy;
  logic            done;

  int errors = 0;
  int checks = 0;

  // Captured frame
  logic [31:0] got_data [32];
  logic [5:0]  got_idx  [32];
  logic        got_last [32];
  int          n_got;
  int          stall_bad;
  bit          done_ok;
  bit          timed_out;

  // Expected frame
  logic [31:0] exp_data [FW];

  perf_counter_reader #(.NUM_CNT(N), .MAGIC(16'hC0DE)) dut (
    .clk(clk), .reset(reset), .start(start), .cnt_in(cnt_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Build the expected frame from the counter values the bench drove.
  task automatic build_expected(input logic [32*N-1:0] cnts);
    logic [31:0] x;
    x = 32'hC0DE0012;
    exp_data[0] = 32'hC0DE0012;
    for (int i = 0; i < N; i++) begin
      exp_data[i+1] = cnts[32*i +: 32];
      x = x ^ cnts[32*i +: 32];
    end
    exp_data[N+1] = x;
  endtask

  // Record transfers from the current negedge until the last word, then step
  // into the DONE cycle. Ready is 1 always, or the 1,0,0,1 pattern.
  task automatic capture(input bit toggle_ready);
    bit          stalled;
    bit          fin;
    logic [31:0] hd;
    logic [5:0]  hi;
    logic        hl;
    n_got = 0; stall_bad = 0; done_ok = 0; timed_out = 1; stalled = 0; fin = 0;
    hd = '0; hi = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      out_ready = toggle_ready ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (n_got > 0 && out_valid !== 1'b1) stall_bad++;
      if (stalled && (out_data !== hd || out_idx !== hi || out_last !== hl)) stall_bad++;
      stalled = 0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          if (n_got < 32) begin
            got_data[n_got] = out_data;
            got_idx[n_got]  = out_idx;
            got_last[n_got] = out_last;
          end
          n_got++;
          if (out_last === 1'b1) begin
            @(negedge clk);
            done_ok   = (done === 1'b1) && (out_valid === 1'b0) && (busy === 1'b1);
            timed_out = 0;
            fin       = 1;
          end
        end else begin
          stalled = 1; hd = out_data; hi = out_idx; hl = out_last;
        end
      end
      if (!fin) @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic launch(input logic [32*N-1:0] cnts);
    cnt_in = cnts;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  function automatic logic [32*N-1:0] ramp(input logic [31:0] base, input logic [31:0] step);
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = base + step * i;
    return v;
  endfunction

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; out_ready = 1'b1; cnt_in = ramp(32'd1, 32'd1);
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_idx, out_last, busy, done} !== 41'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h idx=%0d last=%b busy=%b done=%b, want all 0",
               out_valid, out_data, out_idx, out_last, busy, done);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b valid=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_stream;
    logic [32*N-1:0] c;
    c = ramp(32'd1, 32'd1);
    launch(c);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || out_idx !== 6'd0) begin
      errors++;
      $display("FAIL stream_latency: got valid=%b busy=%b idx=%0d, want 1 1 0", out_valid, busy, out_idx);
    end
    capture(1'b0);
    build_expected(c);
    checks++;
    if (timed_out || n_got != FW) begin
      errors++;
      $display("FAIL stream_count: got %0d words (timeout=%0b), want %0d", n_got, timed_out, FW);
    end
    for (int i = 0; i < FW && i < n_got; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_idx[i] !== 6'(i) || got_last[i] !== (i == FW - 1)) begin
        errors++;
        $display("FAIL stream_word%0d: got data=%h idx=%0d last=%b, want data=%h idx=%0d last=%b",
                 i, got_data[i], got_idx[i], got_last[i], exp_data[i], i, (i == FW - 1));
      end
    end
    checks++;
    if (got_data[FW-1] !== 32'hC0DE0001) begin
      errors++;
      $display("FAIL stream_checksum: got %h, want c0de0001", got_data[FW-1]);
    end
    checks++;
    if (!done_ok) begin
      errors++;
      $display("FAIL stream_done: got done=%b valid=%b busy=%b, want 1 0 1", done, out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL stream_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_stall;
    logic [32*N-1:0] c;
    c = ramp(32'd1, 32'd1);
    launch(c);
    start = 1'b1;     // held during the frame: must not spawn another one
    capture(1'b1);
    start = 1'b0;
    build_expected(c);
    checks++;
    if (timed_out || n_got != FW || stall_bad != 0) begin
      errors++;
      $display("FAIL stall_count: got %0d words, %0d stall violations, want %0d words, 0 violations",
               n_got, stall_bad, FW);
    end
    for (int i = 0; i < FW && i < n_got; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_idx[i] !== 6'(i) || got_last[i] !== (i == FW - 1)) begin
        errors++;
        $display("FAIL stall_word%0d: got data=%h idx=%0d last=%b, want data=%h idx=%0d",
                 i, got_data[i], got_idx[i], got_last[i], exp_data[i], i);
      end
    end
    checks++;
    if (!done_ok) begin
      errors++;
      $display("FAIL stall_done: got done=%b valid=%b, want 1 0", done, out_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_extra_frame: got busy=%b valid=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_snapshot;
    logic [32*N-1:0] c;
    c = ramp(32'd1, 32'd1);
    c[32*5 +: 32] = 32'd7;
    launch(c);
    cnt_in[32*5 +: 32] = 32'd9;   // after the capture edge
    capture(1'b0);
    build_expected(c);
    checks++;
    if (n_got != FW || got_data[6] !== 32'd7) begin
      errors++;
      $display("FAIL snapshot_word6: got %h (%0d words), want 00000007", got_data[6], n_got);
    end
    checks++;
    if (got_data[FW-1] !== exp_data[FW-1]) begin
      errors++;
      $display("FAIL snapshot_checksum: got %h, want %h", got_data[FW-1], exp_data[FW-1]);
    end
    @(negedge clk);
  endtask

  task automatic test_all_ones;
    logic [32*N-1:0] c;
    c = '1;
    launch(c);
    capture(1'b0);
    checks++;
    if (n_got != FW) begin
      errors++;
      $display("FAIL ones_count: got %0d words, want %0d", n_got, FW);
    end
    for (int i = 1; i <= N && i < n_got; i++) begin
      checks++;
      if (got_data[i] !== 32'hFFFFFFFF) begin
        errors++;
        $display("FAIL ones_word%0d: got %h, want ffffffff", i, got_data[i]);
      end
    end
    checks++;
    if (got_data[FW-1] !== 32'hC0DE0012) begin
      errors++;
      $display("FAIL ones_checksum: got %h, want c0de0012", got_data[FW-1]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    logic [32*N-1:0] c;
    bit found;
    found = 0;
    launch(ramp(32'h100, 32'h3));
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1 && out_idx === 6'd8) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_reach_idx8: got idx=%0d valid=%b, want idx 8 presented", out_idx, out_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_idx, out_last, busy, done} !== 41'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b data=%h idx=%0d last=%b busy=%b done=%b, want all 0",
               out_valid, out_data, out_idx, out_last, busy, done);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_aborted: got valid=%b busy=%b, want 0 0", out_valid, busy);
    end
    c = ramp(32'hA5A50000, 32'h11);
    launch(c);
    capture(1'b0);
    build_expected(c);
    checks++;
    if (n_got != FW) begin
      errors++;
      $display("FAIL midreset_refr_count: got %0d words, want %0d", n_got, FW);
    end
    for (int i = 0; i < FW && i < n_got; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_idx[i] !== 6'(i)) begin
        errors++;
        $display("FAIL midreset_word%0d: got data=%h idx=%0d, want data=%h idx=%0d",
                 i, got_data[i], got_idx[i], exp_data[i], i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [32*N-1:0] c;
    c = ramp(32'h00010000, 32'h101);
    cnt_in = c;
    start  = 1'b1;
    @(negedge clk);
    build_expected(c);
    for (int f = 0; f < 2; f++) begin
      capture(1'b0);
      checks++;
      if (n_got != FW || !done_ok) begin
        errors++;
        $display("FAIL b2b_frame%0d: got %0d words done_ok=%0b, want %0d words done_ok=1", f, n_got, done_ok, FW);
      end
      for (int i = 0; i < FW && i < n_got; i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_idx[i] !== 6'(i)) begin
          errors++;
          $display("FAIL b2b_frame%0d_word%0d: got data=%h idx=%0d, want data=%h idx=%0d",
                   f, i, got_data[i], got_idx[i], exp_data[i], i);
        end
      end
      if (f == 1) start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap%0d: got busy=%b valid=%b, want 0 0 (IDLE)", f, busy, out_valid);
      end
      @(negedge clk);
      if (f == 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 6'd0) begin
          errors++;
          $display("FAIL b2b_restart: got valid=%b idx=%0d, want 1 0", out_valid, out_idx);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_stop: got valid=%b busy=%b, want 0 0", out_valid, busy);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; cnt_in = '0;
    @(negedge clk);
    test_reset;
    test_stream;
    test_stall;
    test_snapshot;
    test_all_ones;
    test_reset_midframe;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_counter_reader.md
PERF_COUNTER_READER -- requirements
Module: perf_counter_reader

Interface
REQ-001 Parameters SHALL be:
- NUM_CNT, default 18: number of 32-bit counters read.
- MAGIC, default 16'hC0DE: header tag.
REQ-002 Ports SHALL be as follows; there is one clock, and reset is synchronous and active-high:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  dump request, level-sampled
- cnt_in  in  32*NUM_CNT  flat counter bus; word i = cnt_in[32*i+31:32*i]
- out_ready  in  1  sink accepts word
- out_valid  out  1  word present
- out_data  out  32  word payload
- out_idx  out  6  word position in frame, 0..NUM_CNT+1
- out_last  out  1  high on the final (checksum) word
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after final word accepted
REQ-003 Default map of cnt_in word index SHALL be:
- 0 ADD, 1 SUB, 2 ADDI, 3 ADD_FP, 4 MUL_FP, 5 VADD_FP, 6 VMUL_FP, 7 VSUM_FP, 8 VSET_FP
- 9 SW, 10 LW, 11 SW_FP, 12 LW_FP, 13 VST, 14 VLD, 15 BEQ, 16 BLT, 17 J

Function
REQ-004 FSM states SHALL be IDLE, HDR, DATA, CSUM, DONE.
REQ-005 IDLE with start=1 at a clk edge SHALL, on that same edge:
- register all NUM_CNT words of cnt_in into a snapshot
- enter HDR
- assert out_valid and busy from the next cycle
REQ-006 Frame content SHALL be the snapshot only; cnt_in changes after the snapshot edge SHALL NOT affect the frame.
REQ-007 Frame SHALL be NUM_CNT+2 words in this order:
- idx 0: header = {MAGIC, 8'h00, NUM_CNT[7:0]}
- idx 1..NUM_CNT: snapshot word idx-1
- idx NUM_CNT+1: checksum
REQ-008 Checksum SHALL be the bitwise XOR of the header and all NUM_CNT snapshot words.
REQ-009 A word SHALL transfer on an edge with out_valid=1 and out_ready=1; a transfer SHALL then present the next word in the following cycle (one word per cycle when out_ready is held high).
REQ-010 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-011 out_valid SHALL remain high until the word transfers; it SHALL never deassert mid-frame.
REQ-012 State transitions SHALL be:
- HDR->DATA on header transfer
- DATA->CSUM on transfer of idx NUM_CNT
- CSUM->DONE on checksum transfer
- DONE->IDLE unconditionally after one cycle
REQ-013 In DONE, done=1, out_valid=0 and busy=1; in IDLE, busy=0.
REQ-014 start SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-015 out_last SHALL be 1 exactly while the checksum word is presented.
REQ-016 Counter values SHALL be passed unmodified, including 32'hFFFFFFFF; no saturation or width change.
REQ-017 With start held high continuously, back-to-back frames SHALL be separated by exactly one DONE cycle plus one IDLE cycle.
REQ-018 When out_valid=0, out_data, out_idx and out_last SHALL be 0.

Reset
REQ-019 reset=1 at a clk edge SHALL force:
- state IDLE
- out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0
- snapshot and checksum registers cleared to 0
REQ-020 Reset mid-frame SHALL abort the frame; no further words SHALL be emitted, and the next frame SHALL restart at idx 0 with a fresh snapshot.
REQ-021 reset SHALL take priority over start in the same cycle.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- cnt_in word i = i+1, start pulse, out_ready=1 -> 20 words on consecutive cycles: 32'hC0DE0012, 1..18, then checksum = 32'hC0DE0012 ^ (XOR of 1..18); out_last on idx 19; done one cycle later.
- Same frame with out_ready toggling 1,0,0,1 repeating -> identical word sequence; data, idx and last stable during every stall; no word dropped or duplicated.
- cnt_in word 5 changed from 7 to 9 one cycle after start -> frame carries 7 at idx 6.
- All counters 32'hFFFFFFFF -> data words all 32'hFFFFFFFF; checksum = 32'hC0DE0012 (even number of ones-words).
- reset asserted while idx=8 is presented -> all outputs 0 next cycle; a following start yields a full frame from idx 0.
- start held high continuously -> frames repeat; start pulses during busy produce no extra frame.
